muldiv_unit: RTL and testbench

- Iterative MIPS multiply/divide unit with architectural HI/LO registers; executes mult, multu, div, divu, mthi and mtlo.
- Sits directly downstream of the register file: operands come straight from regfile A_data/B_data.
- HI/LO outputs feed the mfhi/mflo writeback path into the regfile W_data mux.
- Multi-cycle; the busy output is consumed by the hazard/stall logic.

---
 rtl/muldiv_pkg.sv | 17 +
 rtl/muldiv_core.sv | 57 +++++
 rtl/muldiv_unit.sv | 108 ++++++++++
 tb/tb_muldiv_unit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes and FSM state encoding shared by the multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } state_e;

endpackage

// File: rtl/muldiv_core.sv
// muldiv_core: unsigned iterative engine, one shift-add (mult) or restoring shift-sub (div) per enabled cycle.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             div_i,
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic             last_o,
    output logic [width-1:0] hi_o,
    output logic [width-1:0] lo_o
);
    localparam int CW = $clog2(width);

    // mult: {partial product, remaining multiplier}; div: {remainder, dividend bits shifting out / quotient shifting in}
    logic [2*width-1:0] acc_q, acc_d;
    logic [width-1:0]   opb_q, opb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [width:0]     r, sum;
    logic [width-1:0]   rem_n;
    logic               ge;

    always_comb begin
        r     = {acc_q[2*width-1:width], acc_q[width-1]};
        ge    = r >= {1'b0, opb_q};
        rem_n = ge ? width'(r - {1'b0, opb_q}) : r[width-1:0];
        sum   = {1'b0, acc_q[2*width-1:width]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        acc_d = load_i ? {{width{1'b0}}, a_i} :
                !en_i  ? acc_q :
                div_i  ? {rem_n, acc_q[width-2:0], ge} :
                         {sum, acc_q[width-1:1]};
        opb_d = load_i ? b_i : opb_q;
        cnt_d = load_i ? CW'(width - 1) : en_i ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            opb_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            opb_q <= opb_d;
            cnt_q <= cnt_d;
        end
    end

    assign last_o = cnt_q == '0;
    assign hi_o   = acc_q[2*width-1:width];
    assign lo_o   = acc_q[width-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: MIPS HI/LO multiply/divide unit; FSM, sign handling and HI/LO registers around muldiv_core.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] hi,
    output logic [width-1:0] lo
);
    state_e             state_q, state_d;
    logic               sa_q, sa_d, sb_q, sb_d, div_q, div_d, done_q, done_d;
    logic [width-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               md_op, sgn_op, load, en, last;
    logic [width-1:0]   abs_a, abs_b, core_hi, core_lo, q_fix, r_fix;
    logic [2*width-1:0] p_fix;

    assign md_op  = op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
    assign sgn_op = op == MD_MULT || op == MD_DIV;
    // |most-negative| wraps to itself, which is the correct unsigned magnitude
    assign abs_a  = (sgn_op && A[width-1]) ? -A : A;
    assign abs_b  = (sgn_op && B[width-1]) ? -B : B;
    assign p_fix  = (sa_q ^ sb_q) ? -{core_hi, core_lo} : {core_hi, core_lo};
    assign q_fix  = (sa_q ^ sb_q) ? -core_lo : core_lo;
    assign r_fix  = sa_q ? -core_hi : core_hi;

    muldiv_core #(.width(width)) u_core (
        .clk    (clk),
        .reset  (reset),
        .load_i (load),
        .en_i   (en),
        .div_i  (div_q),
        .a_i    (abs_a),
        .b_i    (abs_b),
        .last_o (last),
        .hi_o   (core_hi),
        .lo_o   (core_lo)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        load    = 1'b0;
        en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && md_op) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                    sa_d    = sgn_op & A[width-1];
                    sb_d    = sgn_op & B[width-1];
                    div_d   = op == MD_DIV || op == MD_DIVU;
                end
                hi_d = (start && op == MD_MTHI) ? A : hi_q;
                lo_d = (start && op == MD_MTLO) ? A : lo_q;
            end
            ST_RUN: begin
                en      = 1'b1;
                state_d = last ? ST_FIX : ST_RUN;
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                hi_d    = div_q ? r_fix : p_fix[2*width-1:width];
                lo_d    = div_q ? q_fix : p_fix[width-1:0];
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = state_q != ST_IDLE;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed HI/LO results, latency and abort checks.
module tb_muldiv_unit
    import muldiv_pkg::*;
;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done;
    logic [31:0] hi, lo;
    int          total = 0;
    int          bad = 0;

    muldiv_unit #(.width(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 64) begin
            n += int'(busy);
            @(negedge clk);
        end
        chk({tag, "_lat"}, 64'(n), 64'd33);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int          nd;
        logic [31:0] gh, gl;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        run_md("mult_7_m3", MD_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_md("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

        @(negedge clk);
        start = 1'b1; op = MD_MTHI; A = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        chk("mthi_lo", 64'(lo), 64'h1);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);

        run_md("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_md("divu_z", MD_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_md("div_negz", MD_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'd1);

        // starts issued while busy must be dropped, including MTLO
        @(negedge clk);
        start = 1'b1; op = MD_DIVU; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; op = MD_MTLO; A = 32'hDEAD;
        @(negedge clk);
        op = MD_MULT; A = 32'd3; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", 64'(busy), 64'd1);
        chk("ign_lo_hold", 64'(lo), 64'd1);
        chk("ign_hi_hold", 64'(hi), 64'hFFFF_FFFB);
        nd = 0; gh = '0; gl = '0;
        for (int c = 0; c < 60; c++) begin
            if (done) begin
                nd++; gh = hi; gl = lo;
            end
            @(negedge clk);
        end
        chk("ign_ndone", 64'(nd), 64'd1);
        chk("ign_lo", 64'(gl), 64'd14);
        chk("ign_hi", 64'(gh), 64'd2);
        chk("ign_idle", 64'(busy), 64'd0);
        chk("ign_lo_after", 64'(lo), 64'd14);

        @(negedge clk);
        start = 1'b1; op = MD_MULT; A = 32'd5; B = 32'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("abort_busy_pre", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            nd += int'(done);
            @(negedge clk);
        end
        chk("abort_nodone", 64'(nd), 64'd0);

        run_md("multu_3_4", MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
